// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter with a pending-write scoreboard.
// Requester A (pipeline writeback) normally wins. Requester B (multi-cycle
// unit) wins when A is idle, or once it has been denied STARVE_LIMIT
// consecutive cycles. The write port is driven combinationally from the grant.
// The scoreboard marks destinations of issued multi-cycle ops as busy until
// B writes them back.
module regfile_write_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  input  logic [4:0]      a_addr,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [4:0]      b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            rsv_valid,
  input  logic [4:0]      rsv_addr,
  input  logic [4:0]      q1_addr,
  input  logic [4:0]      q2_addr,
  output logic            q1_busy,
  output logic            q2_busy,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] di3,
  output logic            we3
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic [31:0] busy;
  logic        grant_a;
  logic        grant_b;
  logic        starved;

  // Grant selection: depends only on valids and registered state, never on ready.
  always_comb begin
    starved = 1'b0;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      starved = b_valid && (starve_cnt == LIMIT);
      grant_b = b_valid && (!a_valid || starved);
      grant_a = a_valid && !grant_b;
    end
  end

  // Write port mux: granted requester's address/data, zero when idle.
  always_comb begin
    a3  = '0;
    di3 = '0;
    if (grant_b) begin
      a3  = b_addr;
      di3 = b_data;
    end else if (grant_a) begin
      a3  = a_addr;
      di3 = a_data;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign we3     = (grant_a || grant_b) && (a3 != 5'd0);

  // Starvation counter: counts consecutive denied B cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (b_valid && !grant_b) begin
      if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Scoreboard: B writeback clears, reservation sets; the set is applied last so it wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (grant_b && (b_addr != 5'd0)) busy[b_addr] <= 1'b0;
      if (rsv_valid && (rsv_addr != 5'd0)) busy[rsv_addr] <= 1'b1;
    end
  end

  // Busy queries; register 0 is never busy.
  assign q1_busy = (q1_addr != 5'd0) && busy[q1_addr];
  assign q2_busy = (q2_addr != 5'd0) && busy[q2_addr];

endmodule
